// File: rtl/data_ram.sv
// data_ram: word-organised, byte-writable data memory on the core data bus.
// Combinational 32-bit reads, per-lane writes on the rising clock edge.
//
// Ports:
//   clk          sole clock; writes happen on its rising edge
//   rst_n        synchronous active-low reset; suppresses writes only
//   address      word address (byte address [31:2]); low ADDR_BITS decoded
//   data_i       store data, lanes aligned to byte_enable
//   data_o       load data: addressed word when rd=1, zero otherwise
//   rd           read strobe
//   wr           write strobe
//   byte_enable  per-lane write enable, bit n -> data_i[8n+7:8n]
module data_ram #(
    parameter int ADDR_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] address,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        rd,
    input  logic        wr,
    input  logic [3:0]  byte_enable
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // Contents start at zero and are never cleared by reset.
    logic [31:0] mem [DEPTH] = '{default: '0};

    logic [ADDR_BITS-1:0] idx;

    // Upper address bits are ignored so accesses alias modulo DEPTH.
    assign idx = address[ADDR_BITS-1:0];

    generate
        if (ADDR_BITS < 30) begin : g_unused_addr
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[29:ADDR_BITS];
        end
    endgenerate

    // Unselected lanes keep their previous contents.
    always_ff @(posedge clk) begin
        if (rst_n && wr) begin
            for (int n = 0; n < 4; n++) begin
                if (byte_enable[n]) begin
                    mem[idx][8*n +: 8] <= data_i[8*n +: 8];
                end
            end
        end
    end

    // Full word returned; the core does lane select and sign extension.
    assign data_o = rd ? mem[idx] : 32'h0;

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed scoreboard bench for data_ram.
// Stimulus pushes expected load data; a negedge monitor pops and compares.
module tb_data_ram;

    logic        clk;
    logic        rst_n;
    logic [29:0] address;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        rd;
    logic        wr;
    logic [3:0]  byte_enable;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   tests;
    int   fails;

    data_ram #(.ADDR_BITS(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address     (address),
        .data_i      (data_i),
        .data_o      (data_o),
        .rd          (rd),
        .wr          (wr),
        .byte_enable (byte_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: inputs settle #1 after posedge, so negedge sees this cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t it;
            it = sb.pop_front();
            tests++;
            if (data_o !== it.exp) begin
                fails++;
                $display("FAIL %s: data_o=%h expected=%h",
                         it.name, data_o, it.exp);
            end
        end
    end

    // One cycle of stimulus; optionally queue an expected read value.
    task automatic step(input logic        rst_v,
                        input logic        rd_v,
                        input logic        wr_v,
                        input logic [3:0]  be_v,
                        input logic [29:0] addr_v,
                        input logic [31:0] din_v,
                        input logic        chk,
                        input logic [31:0] exp_v,
                        input string       name);
        exp_t it;
        @(posedge clk);
        #1;
        rst_n       = rst_v;
        rd          = rd_v;
        wr          = wr_v;
        byte_enable = be_v;
        address     = addr_v;
        data_i      = din_v;
        if (chk) begin
            it.exp  = exp_v;
            it.name = name;
            sb.push_back(it);
        end
    endtask

    task automatic wr_word(input logic [29:0] a, input logic [3:0] be,
                           input logic [31:0] d);
        step(1'b1, 1'b0, 1'b1, be, a, d, 1'b0, 32'h0, "");
    endtask

    task automatic rd_chk(input logic rst_v, input logic [29:0] a,
                          input logic [31:0] e, input string name);
        step(rst_v, 1'b1, 1'b0, 4'h0, a, 32'h0, 1'b1, e, name);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        byte_enable = 4'h0;
        address     = '0;
        data_i      = '0;

        // Power-up reads (reset still asserted, reads must work).
        rd_chk(1'b0, 30'h0, 32'h0, "pwrup_0");
        rd_chk(1'b0, 30'h1234, 32'h0, "pwrup_1234");
        step(1'b0, 1'b0, 1'b0, 4'h0, 30'h1234, 32'h0, 1'b1, 32'h0,
             "rd0_pwrup");

        // Full-word write/read.
        wr_word(30'h10, 4'b1111, 32'hDEADBEEF);
        rd_chk(1'b1, 30'h10, 32'hDEADBEEF, "full_word");
        rd_chk(1'b1, 30'h11, 32'h0, "neighbour");
        step(1'b1, 1'b0, 1'b0, 4'h0, 30'h10, 32'h0, 1'b1, 32'h0,
             "rd0_written");

        // Byte lanes.
        wr_word(30'h20, 4'b1111, 32'h11223344);
        rd_chk(1'b1, 30'h20, 32'h11223344, "preload");
        wr_word(30'h20, 4'b0001, 32'hAABBCCDD);
        rd_chk(1'b1, 30'h20, 32'h112233DD, "lane0");
        wr_word(30'h20, 4'b1100, 32'h55660000);
        rd_chk(1'b1, 30'h20, 32'h556633DD, "lane23");
        wr_word(30'h20, 4'b0000, 32'hFFFFFFFF);
        rd_chk(1'b1, 30'h20, 32'h556633DD, "be_none");
        wr_word(30'h20, 4'b0010, 32'h0000EE00);
        rd_chk(1'b1, 30'h20, 32'h5566EEDD, "lane1");

        // Read-during-write.
        wr_word(30'h30, 4'b1111, 32'h1);
        step(1'b1, 1'b1, 1'b1, 4'b1111, 30'h30, 32'h2, 1'b1, 32'h1,
             "rdw_before");
        rd_chk(1'b1, 30'h30, 32'h2, "rdw_after");

        // Reset suppresses writes.
        step(1'b0, 1'b0, 1'b1, 4'b1111, 30'h40, 32'hCAFEF00D, 1'b0,
             32'h0, "");
        rd_chk(1'b0, 30'h40, 32'h0, "rst_wr_drop");
        wr_word(30'h40, 4'b1111, 32'hCAFEF00D);
        rd_chk(1'b1, 30'h40, 32'hCAFEF00D, "post_rst_wr");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 4'b1111, 30'h40, 32'hFFFFFFFF, 1'b0,
                 32'h0, "");
        end
        rd_chk(1'b0, 30'h40, 32'hCAFEF00D, "rst_retain");
        rd_chk(1'b1, 30'h10, 32'hDEADBEEF, "rst_retain_10");

        // Aliasing modulo 2^16 words.
        wr_word(30'h0001_0005, 4'b1111, 32'h0BADF00D);
        rd_chk(1'b1, 30'h0000_0005, 32'h0BADF00D, "alias_lo");
        rd_chk(1'b1, 30'h3FFF_0005, 32'h0BADF00D, "alias_hi");
        rd_chk(1'b1, 30'h0000_0006, 32'h0, "alias_next");

        step(1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 32'h0, "");
        step(1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 32'h0, "");

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
